// File: rtl/fifo_word_packer.sv
// Packs bytes read from an upstream FIFO into LANES-byte words, first byte in
// the low lane, with flush for partial words and an accepted-word counter.
module fifo_word_packer #(
   parameter int LANES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fifo_empty,
   input  logic [7:0]         fifo_data_out,
   output logic               fifo_rd_en,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*LANES-1:0] out_data,
   output logic [3:0]         out_bytes,
   output logic [15:0]        word_count
);

   typedef enum logic [0:0] {COLLECT = 1'b0, OUTPUT = 1'b1} state_t;

   localparam logic [3:0] LANES_C = 4'(LANES);

   state_t               state_r, state_s;
   logic [3:0]           byte_cnt_r, byte_cnt_s;
   logic                 rd_pend_r;
   logic                 rd_en_s;
   logic                 flush_latched_r, flush_latched_s;
   logic [8*LANES-1:0]   data_r, data_s;
   logic [3:0]           bytes_r, bytes_s;
   logic                 valid_r, valid_s;
   logic [15:0]          word_count_r, word_count_s;

   // Read strobe: collecting, data available, no flush pending and room for one more byte.
   always_comb begin
      rd_en_s = 1'b0;
      if (rst && (state_r == COLLECT) && !fifo_empty && !flush_latched_r &&
          ((byte_cnt_r + {3'b000, rd_pend_r}) < LANES_C)) begin
         rd_en_s = 1'b1;
      end else begin
         rd_en_s = 1'b0;
      end
   end

   // Next-state and datapath update for the collect/output handshake.
   always_comb begin
      state_s         = state_r;
      byte_cnt_s      = byte_cnt_r;
      flush_latched_s = flush_latched_r;
      data_s          = data_r;
      bytes_s         = bytes_r;
      valid_s         = valid_r;
      word_count_s    = word_count_r;
      case (state_r)
         COLLECT: begin
            if (flush) begin
               flush_latched_s = 1'b1;
            end else begin
               flush_latched_s = flush_latched_r;
            end
            if (rd_pend_r) begin
               for (int i = 0; i < LANES; i++) begin
                  if (byte_cnt_r == 4'(i)) begin
                     data_s[8*i +: 8] = fifo_data_out;
                  end else begin
                     data_s[8*i +: 8] = data_r[8*i +: 8];
                  end
               end
               byte_cnt_s = byte_cnt_r + 4'd1;
               if (byte_cnt_s == LANES_C) begin
                  state_s         = OUTPUT;
                  valid_s         = 1'b1;
                  bytes_s         = LANES_C;
                  flush_latched_s = 1'b0;
               end else begin
                  state_s = COLLECT;
               end
            end else if (flush_latched_r) begin
               // Flush acts only once no read is in flight, so no byte is lost.
               if (byte_cnt_r != 4'd0) begin
                  state_s         = OUTPUT;
                  valid_s         = 1'b1;
                  bytes_s         = byte_cnt_r;
                  flush_latched_s = 1'b0;
               end else begin
                  flush_latched_s = 1'b0;
               end
            end else begin
               state_s = COLLECT;
            end
         end
         OUTPUT: begin
            flush_latched_s = 1'b0;
            if (valid_r && out_ready) begin
               state_s      = COLLECT;
               byte_cnt_s   = 4'd0;
               data_s       = '0;
               bytes_s      = 4'd0;
               valid_s      = 1'b0;
               word_count_s = word_count_r + 16'd1;
            end else begin
               state_s = OUTPUT;
            end
         end
         default: begin
            state_s         = COLLECT;
            byte_cnt_s      = 4'd0;
            flush_latched_s = 1'b0;
            data_s          = '0;
            bytes_s         = 4'd0;
            valid_s         = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any partial word and in-flight read.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r         <= COLLECT;
         byte_cnt_r      <= 4'd0;
         rd_pend_r       <= 1'b0;
         flush_latched_r <= 1'b0;
         data_r          <= '0;
         bytes_r         <= 4'd0;
         valid_r         <= 1'b0;
         word_count_r    <= 16'd0;
      end else begin
         state_r         <= state_s;
         byte_cnt_r      <= byte_cnt_s;
         rd_pend_r       <= rd_en_s;
         flush_latched_r <= flush_latched_s;
         data_r          <= data_s;
         bytes_r         <= bytes_s;
         valid_r         <= valid_s;
         word_count_r    <= word_count_s;
      end
   end

   assign fifo_rd_en = rd_en_s;
   assign out_valid  = valid_r;
   assign out_data   = data_r;
   assign out_bytes  = bytes_r;
   assign word_count = word_count_r;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: behavioural upstream FIFO, expected-word scoreboard
// checked on every downstream acceptance, plus per-scenario inline checks.
module tb_fifo_word_packer;

   logic        clk;
   logic        rst;
   logic        fifo_empty;
   logic [7:0]  fifo_data_out;
   logic        fifo_rd_en;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_bytes;
   logic [15:0] word_count;

   int          errors = 0;
   int          checks = 0;

   logic [7:0]  fifo_q[$];
   logic [31:0] exp_data_q[$];
   logic [3:0]  exp_bytes_q[$];
   logic [15:0] wc_model = 16'd0;
   logic        stall_force = 1'b0;
   logic        hold_pending = 1'b0;
   logic [31:0] hold_data;
   logic [3:0]  hold_bytes;

   fifo_word_packer #(.LANES(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .fifo_empty    (fifo_empty),
      .fifo_data_out (fifo_data_out),
      .fifo_rd_en    (fifo_rd_en),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_bytes     (out_bytes),
      .word_count    (word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Scoreboard monitor: word content on acceptance, hold stability, counter tracking.
   always @(negedge clk) begin
      if (rst) begin
         checks++;
         if (word_count !== wc_model) begin
            errors++;
            $display("FAIL word_count: got %h expected %h", word_count, wc_model);
         end
         if (out_valid) begin
            checks++;
            if (fifo_rd_en !== 1'b0) begin
               errors++;
               $display("FAIL rd_en_in_output: got %b expected 0", fifo_rd_en);
            end
         end
         if (hold_pending) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== hold_data || out_bytes !== hold_bytes) begin
               errors++;
               $display("FAIL hold_stable: got v=%b d=%h b=%0d expected v=1 d=%h b=%0d",
                        out_valid, out_data, out_bytes, hold_data, hold_bytes);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_data_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word: got d=%h b=%0d expected no word", out_data, out_bytes);
            end else begin
               logic [31:0] ed;
               logic [3:0]  eb;
               ed = exp_data_q.pop_front();
               eb = exp_bytes_q.pop_front();
               if (out_data !== ed || out_bytes !== eb) begin
                  errors++;
                  $display("FAIL word: got d=%h b=%0d expected d=%h b=%0d", out_data, out_bytes, ed, eb);
               end
            end
            wc_model     = wc_model + 16'd1;
            hold_pending = 1'b0;
         end else if (out_valid) begin
            hold_pending = 1'b1;
            hold_data    = out_data;
            hold_bytes   = out_bytes;
         end else begin
            hold_pending = 1'b0;
         end
      end else begin
         hold_pending = 1'b0;
      end
   end

   task automatic refresh();
      fifo_empty = stall_force || (fifo_q.size() == 0);
   endtask

   // One cycle: sample strobe/valid mid-cycle, then model the FIFO read after the edge.
   task automatic tick(output logic rd_s, output logic ov_s);
      @(negedge clk);
      rd_s = fifo_rd_en;
      ov_s = out_valid;
      @(posedge clk);
      #2;
      if (rd_s) begin
         if (fifo_q.size() > 0) fifo_data_out = fifo_q.pop_front();
         else fifo_data_out = 8'hEE;
      end
      refresh();
   endtask

   task automatic push_word(input logic [31:0] w, input logic [3:0] n);
      for (int i = 0; i < 4; i++) begin
         if (i < int'(n)) fifo_q.push_back(w[8*i +: 8]);
      end
      exp_data_q.push_back(w);
      exp_bytes_q.push_back(n);
      refresh();
   endtask

   task automatic wait_drain(output bit ok);
      logic rd, ov;
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (exp_data_q.size() == 0 && !out_valid) begin
            ok = 1'b1;
            break;
         end
         tick(rd, ov);
      end
   endtask

   task automatic test_reset();
      logic rd, ov;
      fifo_q.push_back(8'h99);
      refresh();
      out_ready = 1'b1;
      tick(rd, ov);
      checks++;
      if (rd !== 1'b0) begin
         errors++;
         $display("FAIL reset_rd_en: got %b expected 0", rd);
      end
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_bytes !== 4'd0 || word_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b d=%h b=%0d wc=%h expected all zero",
                  out_valid, out_data, out_bytes, word_count);
      end
      fifo_q.delete();
      refresh();
      wc_model = 16'd0;
      rst = 1'b1;
      tick(rd, ov);
   endtask

   task automatic test_stream();
      logic rd, ov;
      out_ready = 1'b1;
      push_word(32'h44332211, 4'd4);
      for (int c = 0; c < 6; c++) begin
         tick(rd, ov);
         checks++;
         if (rd !== ((c < 4) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL stream_rd_en cycle %0d: got %b expected %b", c, rd, (c < 4));
         end
         checks++;
         if (ov !== ((c == 5) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL stream_valid cycle %0d: got %b expected %b", c, ov, (c == 5));
         end
      end
      tick(rd, ov);
      checks++;
      if (word_count !== 16'd1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_accept: got wc=%h v=%b expected wc=0001 v=0", word_count, out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic rd, ov;
      bit   ok;
      out_ready = 1'b0;
      push_word(32'hC33CA55A, 4'd4);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick(rd, ov);
         if (out_valid) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_valid_timeout: got no out_valid expected out_valid within 20 cycles");
      end
      for (int i = 0; i < 10; i++) begin
         flush = (i == 3) ? 1'b1 : 1'b0;
         tick(rd, ov);
         checks++;
         if (rd !== 1'b0 || ov !== 1'b1 || out_data !== 32'hC33CA55A || out_bytes !== 4'd4) begin
            errors++;
            $display("FAIL bp_hold %0d: got rd=%b v=%b d=%h b=%0d expected rd=0 v=1 d=c33ca55a b=4",
                     i, rd, ov, out_data, out_bytes);
         end
      end
      flush = 1'b0;
      out_ready = 1'b1;
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_drain: got %0d words pending expected 0", exp_data_q.size());
      end
   endtask

   task automatic test_flush();
      logic rd, ov;
      bit   ok;
      bit   seen;
      out_ready = 1'b1;
      push_word(32'h0000B2A1, 4'd2);
      repeat (6) tick(rd, ov);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_premature: got v=%b expected 0", out_valid);
      end
      flush = 1'b1;
      tick(rd, ov);
      flush = 1'b0;
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL flush_partial: got %0d words pending expected 0", exp_data_q.size());
      end
      flush = 1'b1;
      tick(rd, ov);
      flush = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(rd, ov);
         if (ov) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL flush_empty: got out_valid=1 expected no word");
      end
   endtask

   task automatic test_empty_stall();
      logic rd, ov;
      bit   ok;
      out_ready = 1'b1;
      push_word(32'h74737271, 4'd4);
      push_word(32'h78777675, 4'd4);
      for (int i = 0; i < 40; i++) begin
         stall_force = (i % 2) == 1;
         refresh();
         tick(rd, ov);
      end
      stall_force = 1'b0;
      refresh();
      wait_drain(ok);
      checks++;
      if (!ok || fifo_q.size() != 0) begin
         errors++;
         $display("FAIL stall_words: got %0d words and %0d bytes pending expected 0 and 0",
                  exp_data_q.size(), fifo_q.size());
      end
   endtask

   task automatic test_reset_mid();
      logic rd, ov;
      bit   ok;
      out_ready = 1'b1;
      fifo_q.push_back(8'hDE);
      fifo_q.push_back(8'hAD);
      refresh();
      repeat (5) tick(rd, ov);
      rst = 1'b0;
      wc_model = 16'd0;
      tick(rd, ov);
      checks++;
      if (rd !== 1'b0) begin
         errors++;
         $display("FAIL midreset_rd_en: got %b expected 0", rd);
      end
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_bytes !== 4'd0 || word_count !== 16'd0) begin
         errors++;
         $display("FAIL midreset_outputs: got v=%b d=%h b=%0d wc=%h expected all zero",
                  out_valid, out_data, out_bytes, word_count);
      end
      rst = 1'b1;
      push_word(32'h04030201, 4'd4);
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL midreset_word: got %0d words pending expected 0", exp_data_q.size());
      end
   endtask

   task automatic test_wrap();
      logic rd, ov;
      bit   ok;
      out_ready = 1'b1;
      force dut.word_count_r = 16'hFFFF;
      wc_model = 16'hFFFF;
      tick(rd, ov);
      release dut.word_count_r;
      tick(rd, ov);
      checks++;
      if (word_count !== 16'hFFFF) begin
         errors++;
         $display("FAIL wrap_preload: got %h expected ffff", word_count);
      end
      push_word(32'hDDCCBBAA, 4'd4);
      wait_drain(ok);
      checks++;
      if (!ok || word_count !== 16'h0000) begin
         errors++;
         $display("FAIL wrap: got wc=%h drained=%b expected wc=0000 drained=1", word_count, ok);
      end
   endtask

   initial begin
      rst           = 1'b0;
      fifo_empty    = 1'b1;
      fifo_data_out = 8'h00;
      flush         = 1'b0;
      out_ready     = 1'b0;
      @(posedge clk);
      #2;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_empty_stall();
      test_reset_mid();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_word_packer.md
FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 Parameter: LANES, default 4, number of 8-bit bytes packed per output word (legal range 2..8).
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  reset; synchronous and active-low.
REQ-004 Port: fifo_empty  input  1  upstream FIFO empty flag.
REQ-005 Port: fifo_data_out  input  8  upstream FIFO read data, valid the cycle after fifo_rd_en.
REQ-006 Port: fifo_rd_en  output  1  read strobe to the upstream FIFO.
REQ-007 Port: flush  input  1  request to emit a partially filled word.
REQ-008 Port: out_valid  output  1  packed word available.
REQ-009 Port: out_ready  input  1  downstream accepts the word when high with out_valid.
REQ-010 Port: out_data  output  8*LANES  packed word; first byte read sits in bits [7:0].
REQ-011 Port: out_bytes  output  4  number of valid bytes in out_data (1..LANES).
REQ-012 Port: word_count  output  16  total words accepted downstream, wrapping modulo 2^16.

Function
REQ-013 States: COLLECT (reading bytes) and OUTPUT (holding a word); reset state is COLLECT.
REQ-014 fifo_rd_en SHALL be combinational: high only in COLLECT, with fifo_empty low, flush_latched low, and (byte_cnt + rd_pend) < LANES.
REQ-015 rd_pend SHALL be a register set to fifo_rd_en each cycle; when rd_pend is high, fifo_data_out is written into lane byte_cnt and byte_cnt increments.
REQ-016 Unused lanes of out_data SHALL read 0.
REQ-017 COLLECT->OUTPUT when a capture makes byte_cnt equal to LANES; out_valid SHALL be high the following cycle.
REQ-018 Latency: with fifo_empty constantly low and LANES=4, fifo_rd_en is high in cycles 0..3 and out_valid rises in cycle 5.
REQ-019 In OUTPUT, out_data, out_bytes and out_valid SHALL hold stable until out_ready is sampled high; fifo_rd_en stays low.
REQ-020 On out_valid and out_ready: return to COLLECT, clear byte_cnt and out_data, increment word_count; reading resumes in the next cycle.
REQ-021 flush SHALL be latched (flush_latched) when it is high in COLLECT; once rd_pend is low, with byte_cnt>0 go to OUTPUT and emit out_bytes=byte_cnt; with byte_cnt==0 clear flush_latched and stay in COLLECT.
REQ-022 flush is ignored in OUTPUT; flush_latched clears on entry to OUTPUT.
REQ-023 fifo_empty going high mid-word SHALL stall collection with no state change; an in-flight read (rd_pend) still completes.
REQ-024 word_count SHALL wrap from 16'hFFFF to 16'h0000 without a flag.

Reset
REQ-025 When rst is low at a posedge: state=COLLECT, byte_cnt=0, rd_pend=0, flush_latched=0, out_data=0, out_bytes=0, out_valid=0, word_count=0.
REQ-026 While rst is low, fifo_rd_en SHALL be 0.
REQ-027 Reset mid-word or mid-OUTPUT SHALL discard the partial or held word; FIFO data returned for a read in flight at reset is dropped.

Verification
REQ-028 Stream: FIFO holds 8'h11,22,33,44; out_ready=1 -> out_valid in cycle 5, out_data=32'h44332211, out_bytes=4, word_count 0->1.
REQ-029 Backpressure: out_ready=0 for 10 cycles after out_valid -> word stays stable, fifo_rd_en=0 throughout; accepted when out_ready=1.
REQ-030 Partial flush: FIFO holds 8'hA1,B2 then empty; pulse flush -> out_data=32'h0000B2A1, out_bytes=2; flush with byte_cnt=0 -> no word emitted.
REQ-031 Empty stall: empty toggles every other cycle while 8 bytes arrive -> two words in correct byte order; no duplicated or lost bytes.
REQ-032 Reset mid-operation: rst low after 2 captured bytes -> all outputs at reset values next cycle; next 4 bytes form a clean word.
REQ-033 Wrap: preload 65535 accepted words (or force the counter) -> next acceptance gives word_count=0.
